// File: rtl/vga_capture_pkg.sv
// Shared VGA timing constants, write-beat payload and capture FSM state type.
package vga_capture_pkg;

    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BEAT_W = ADDR_W + DATA_W;

    typedef struct packed {
        int unsigned h_sync_len;
        int unsigned h_bp;
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned v_sync_len;
        int unsigned v_bp;
        int unsigned v_active;
        int unsigned v_fp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        h_sync_len: H_SYNC, h_bp: H_BP, h_active: H_ACTIVE, h_fp: H_FP,
        v_sync_len: V_SYNC, v_bp: V_BP, v_active: V_ACTIVE, v_fp: V_FP
    };

    function automatic int unsigned h_total(input vga_timing_t t);
        return t.h_sync_len + t.h_bp + t.h_active + t.h_fp;
    endfunction

    function automatic int unsigned v_total(input vga_timing_t t);
        return t.v_sync_len + t.v_bp + t.v_active + t.v_fp;
    endfunction

    function automatic int unsigned frame_pixels(input vga_timing_t t);
        return t.h_active * t.v_active;
    endfunction

    localparam int unsigned H_TOTAL      = h_total(VGA_640X480);
    localparam int unsigned V_TOTAL      = v_total(VGA_640X480);
    localparam int unsigned FRAME_PIXELS = frame_pixels(VGA_640X480);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_beat_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } cap_state_t;

endpackage

// File: rtl/vga_capture_if.sv
// Frame-buffer write port: valid/ready with byte address and 16-bit pixel word.
interface vga_capture_if;
    import vga_capture_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/vga_capture_fifo.sv
// Synchronous skid FIFO for captured pixel writes; DEPTH must be a power of 2.
module vga_capture_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_capture.sv
// VGA stream capture: locks to incoming sync timing and writes active pixels to memory.
// Define VGA_CAPTURE_STATS_EN to add the frame_cnt / lock_err_cnt statistics outputs.
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter vga_timing_t TIMING     = VGA_640X480,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int unsigned ADDR_SHIFT = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pix_ce,
    input  logic         h_sync,
    input  logic         v_sync,
    input  logic [3:0]   Red,
    input  logic [3:0]   Green,
    input  logic [3:0]   Blue,
    vga_capture_if.master wr,
    output logic         locked,
    output logic         frame_done,
    output logic         overflow,
    input  logic         clr_ovf
`ifdef VGA_CAPTURE_STATS_EN
    ,
    output logic [15:0]  frame_cnt,
    output logic [7:0]   lock_err_cnt
`endif
);

    localparam int unsigned HT    = h_total(TIMING);
    localparam int unsigned VT    = v_total(TIMING);
    localparam int unsigned FP    = frame_pixels(TIMING);
    localparam int unsigned H_LO  = TIMING.h_sync_len + TIMING.h_bp;
    localparam int unsigned H_HI  = H_LO + TIMING.h_active;
    localparam int unsigned V_LO  = TIMING.v_sync_len + TIMING.v_bp;
    localparam int unsigned V_HI  = V_LO + TIMING.v_active;
    localparam int unsigned H_MAX = 2 * HT;
    localparam int unsigned V_MAX = 2 * VT;
    localparam int unsigned HW    = $clog2(H_MAX + 1);
    localparam int unsigned VW    = $clog2(V_MAX + 1);
    localparam int unsigned IW    = $clog2(FP);

    logic          smp_vld;
    logic          hs_q, hs_p, vs_q, vs_p;
    logic [11:0]   rgb_q;

    cap_state_t    state_q, state_nxt;
    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic [IW-1:0] idx_q, idx_nxt;
    logic          hs_edge, vs_edge, lock_err, in_win, push_due;
    logic          frame_done_nxt, overflow_nxt;

    logic          fifo_full, fifo_empty, pop;
    wr_beat_t      beat_in, beat_out;

    // Input sampling stage; the previous sync level is kept for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_vld <= 1'b0;
            hs_q    <= ~SYNC_POL;
            hs_p    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            vs_p    <= ~SYNC_POL;
            rgb_q   <= '0;
        end else begin
            smp_vld <= pix_ce;
            if (pix_ce) begin
                hs_p  <= hs_q;
                hs_q  <= h_sync;
                vs_p  <= vs_q;
                vs_q  <= v_sync;
                rgb_q <= {Red, Green, Blue};
            end
        end
    end

    // Timing tracking, lock FSM and capture decision for the sample just registered.
    always_comb begin
        hs_edge        = 1'b0;
        vs_edge        = 1'b0;
        h_nxt          = h_cnt;
        v_nxt          = v_cnt;
        lock_err       = 1'b0;
        in_win         = 1'b0;
        push_due       = 1'b0;
        state_nxt      = state_q;
        idx_nxt        = idx_q;
        frame_done_nxt = 1'b0;
        overflow_nxt   = overflow;

        if (smp_vld) begin
            hs_edge = (hs_q == SYNC_POL) && (hs_p != SYNC_POL);
            vs_edge = (vs_q == SYNC_POL) && (vs_p != SYNC_POL);
            if (hs_edge) begin
                h_nxt = '0;
            end else if (h_cnt != HW'(H_MAX)) begin
                h_nxt = h_cnt + HW'(1);
            end
            if (vs_edge) begin
                v_nxt = '0;
            end else if (hs_edge && (v_cnt != VW'(V_MAX))) begin
                v_nxt = v_cnt + VW'(1);
            end
            lock_err = (hs_edge && (h_cnt != HW'(HT - 1))) || (h_nxt == HW'(H_MAX));
            in_win   = (h_nxt >= HW'(H_LO)) && (h_nxt < HW'(H_HI)) &&
                       (v_nxt >= VW'(V_LO)) && (v_nxt < VW'(V_HI));
        end

        case (state_q)
            UNLOCKED: begin
                if (vs_edge) state_nxt = LOCKED;
            end
            LOCKED: begin
                push_due = smp_vld && in_win && !lock_err;
                if (lock_err) state_nxt = UNLOCKED;
            end
            default: state_nxt = UNLOCKED;
        endcase

        // Dropped pixels still advance the index so later pixels keep their address.
        if (push_due) begin
            frame_done_nxt = (idx_q == IW'(FP - 1));
            idx_nxt        = frame_done_nxt ? '0 : idx_q + IW'(1);
        end
        if (vs_edge || (state_nxt == UNLOCKED)) idx_nxt = '0;

        if (push_due && fifo_full && !pop) begin
            overflow_nxt = 1'b1;
        end else if (clr_ovf) begin
            overflow_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNLOCKED;
            h_cnt      <= '0;
            v_cnt      <= '0;
            idx_q      <= '0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            h_cnt      <= h_nxt;
            v_cnt      <= v_nxt;
            idx_q      <= idx_nxt;
            locked     <= (state_nxt == LOCKED);
            frame_done <= frame_done_nxt;
            overflow   <= overflow_nxt;
        end
    end

    assign beat_in.addr = ADDR_W'(32'(idx_q) << ADDR_SHIFT);
    assign beat_in.data = {4'h0, rgb_q};
    assign pop          = !fifo_empty && wr.wr_ready;

    vga_capture_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_due),
        .pop   (pop),
        .din   (beat_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (beat_out)
    );

    assign wr.wr_valid = !fifo_empty;
    assign wr.wr_addr  = beat_out.addr;
    assign wr.wr_data  = beat_out.data;

`ifdef VGA_CAPTURE_STATS_EN
    // Frame and lock-loss statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt    <= '0;
            lock_err_cnt <= '0;
        end else begin
            if (frame_done_nxt) frame_cnt <= frame_cnt + 16'd1;
            if ((state_q == LOCKED) && (state_nxt == UNLOCKED) && (lock_err_cnt != 8'hFF)) begin
                lock_err_cnt <= lock_err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a reduced 10x6 timing (4x3 active) and pix_ce every 4 clocks.
module tb_vga_capture;
    import vga_capture_pkg::*;

    localparam vga_timing_t TB_T = '{
        h_sync_len: 2, h_bp: 2, h_active: 4, h_fp: 2,
        v_sync_len: 1, v_bp: 1, v_active: 3, v_fp: 1
    };
    localparam int   HT  = 10;
    localparam int   VT  = 6;
    localparam int   HS  = 2;
    localparam int   VS  = 1;
    localparam int   HLO = 4;
    localparam int   VLO = 2;
    localparam int   AX  = 4;
    localparam logic POL = 1'b0;

    logic       clk, rst_n, pix_ce, h_sync, v_sync, clr_ovf;
    logic [3:0] Red, Green, Blue;
    logic       locked, frame_done, overflow;
`ifdef VGA_CAPTURE_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  lock_err_cnt;
`endif

    vga_capture_if wr_if ();

    vga_capture #(
        .TIMING     (TB_T),
        .SYNC_POL   (POL),
        .ADDR_SHIFT (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_ce       (pix_ce),
        .h_sync       (h_sync),
        .v_sync       (v_sync),
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue),
        .wr           (wr_if),
        .locked       (locked),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .clr_ovf      (clr_ovf)
`ifdef VGA_CAPTURE_STATS_EN
        ,
        .frame_cnt    (frame_cnt),
        .lock_err_cnt (lock_err_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          fd_cnt = 0;
    int          fd_base;
    logic [47:0] acc_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record accepted writes and frame_done pulses between clock edges.
    always @(negedge clk) begin
        if (rst_n && wr_if.wr_valid && wr_if.wr_ready) acc_q.push_back({wr_if.wr_addr, wr_if.wr_data});
        if (rst_n && frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] exp_beat(input int idx);
        logic [31:0] a;
        a = 32'(idx) << 4;
        return {a, 4'h0, 4'(idx % AX), 4'(idx / AX), 4'h5};
    endfunction

    task automatic check_writes(input string tag, input int last, input int skip_lo, input int skip_hi);
        int exp_idx [$];
        for (int i = 0; i <= last; i++) if (i < skip_lo || i > skip_hi) exp_idx.push_back(i);
        check({tag, "_count"}, 48'(acc_q.size()), 48'(exp_idx.size()));
        for (int i = 0; i < exp_idx.size() && i < acc_q.size(); i++)
            check({tag, "_beat"}, acc_q[i], exp_beat(exp_idx[i]));
        acc_q.delete();
    endtask

    task automatic pixel(input int x, input int y);
        h_sync = (x < HS) ? POL : ~POL;
        v_sync = (y < VS) ? POL : ~POL;
        Red    = 4'(x - HLO);
        Green  = 4'(y - VLO);
        Blue   = 4'h5;
        pix_ce = 1'b1;
        @(posedge clk); #1;
        pix_ce = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input int short_y, input int ready_y);
        for (int y = 0; y < VT; y++) begin
            wr_if.wr_ready = (y >= ready_y);
            for (int x = 0; x < ((y == short_y) ? HT - 3 : HT); x++) pixel(x, y);
        end
        wr_if.wr_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pix_ce = 1'b0; h_sync = ~POL; v_sync = ~POL;
        Red = '0; Green = '0; Blue = '0; clr_ovf = 1'b0; wr_if.wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_valid", 48'(wr_if.wr_valid), 48'd0);
        check("rst_wr_addr", 48'(wr_if.wr_addr), 48'd0);
        check("rst_wr_data", 48'(wr_if.wr_data), 48'd0);
        check("rst_locked", 48'(locked), 48'd0);
        check("rst_frame_done", 48'(frame_done), 48'd0);
        check("rst_overflow", 48'(overflow), 48'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("pre_lock", 48'(locked), 48'd0);

        // First frame: lock on the first vsync edge and capture every active pixel.
        fd_base = fd_cnt;
        frame(-1, 0);
        check("f1_locked", 48'(locked), 48'd1);
        check("f1_frame_done", 48'(fd_cnt - fd_base), 48'd1);
        check_writes("f1", 11, -1, -1);

        // Known pattern spot checks: first pixel and active pixel (3,2).
        fd_base = fd_cnt;
        frame(-1, 0);
        check("f2_first", acc_q[0], 48'h0000_0000_0005);
        check("f2_px_3_2", acc_q[11], 48'h0000_00B0_0325);
        check("f2_frame_done", 48'(fd_cnt - fd_base), 48'd1);
        check_writes("f2", 11, -1, -1);

        // Back-pressure for two lines: FIFO keeps 0..3, pixels 4..7 are dropped.
        fd_base = fd_cnt;
        frame(-1, 4);
        check("ovf_set", 48'(overflow), 48'd1);
        check("ovf_locked", 48'(locked), 48'd1);
        check("ovf_frame_done", 48'(fd_cnt - fd_base), 48'd1);
        check_writes("ovf", 11, 4, 7);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        check("ovf_clear", 48'(overflow), 48'd0);

        // Line 3 is 3 pixels short: lock lost at the next hsync edge, capture stops.
        fd_base = fd_cnt;
        frame(3, 0);
        check("short_locked", 48'(locked), 48'd0);
        check("short_frame_done", 48'(fd_cnt - fd_base), 48'd0);
        check_writes("short", 6, -1, -1);

        fd_base = fd_cnt;
        frame(-1, 0);
        check("relock_locked", 48'(locked), 48'd1);
        check("relock_frame_done", 48'(fd_cnt - fd_base), 48'd1);
        check_writes("relock", 11, -1, -1);
`ifdef VGA_CAPTURE_STATS_EN
        check("stats_frame_cnt", 48'(frame_cnt), 48'd4);
        check("stats_lock_err_cnt", 48'(lock_err_cnt), 48'd1);
`endif

        // Reset mid-line with three writes queued.
        wr_if.wr_ready = 1'b0;
        for (int y = 0; y < 2; y++) for (int x = 0; x < HT; x++) pixel(x, y);
        for (int x = 0; x < 7; x++) pixel(x, 2);
        check("mid_wr_valid", 48'(wr_if.wr_valid), 48'd1);
        check("mid_head_data", 48'(wr_if.wr_data), 48'h0005);
        rst_n = 1'b0;
        #1;
        check("arst_wr_valid", 48'(wr_if.wr_valid), 48'd0);
        check("arst_wr_data", 48'(wr_if.wr_data), 48'd0);
        check("arst_wr_addr", 48'(wr_if.wr_addr), 48'd0);
        check("arst_locked", 48'(locked), 48'd0);
        check("arst_overflow", 48'(overflow), 48'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_if.wr_ready = 1'b1;
        acc_q.delete();
        for (int x = 7; x < HT; x++) pixel(x, 2);
        for (int y = 3; y < VT; y++) for (int x = 0; x < HT; x++) pixel(x, y);
        check("post_rst_writes", 48'(acc_q.size()), 48'd0);
        check("post_rst_locked", 48'(locked), 48'd0);
        frame(-1, 0);
        check("post_rst_relock", 48'(locked), 48'd1);
        check_writes("post_rst", 11, -1, -1);
`ifdef VGA_CAPTURE_STATS_EN
        check("stats_rst_frame_cnt", 48'(frame_cnt), 48'd1);
        check("stats_rst_lock_err_cnt", 48'(lock_err_cnt), 48'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the VGA timing generator: samples an incoming VGA stream (h_sync, v_sync, 4-bit R/G/B) and locks to its frame timing.
- Captures the active-window pixels and writes them into the frame-buffer memory as 16-bit words over a valid/ready write port.
- Sits between an external video source (or the on-chip generator in loopback) and the memory interconnect.

Parameters:
- H_SYNC, 96, hsync pulse length in pixels
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse length in lines
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch
- SYNC_POL, 0, asserted level of both sync inputs (0 = active-low)
- ADDR_SHIFT, 4, wr_addr = pixel_index << ADDR_SHIFT
- FIFO_DEPTH, 4, write skid FIFO depth (power of 2)

Ports:
- clk  in  1  system clock, shared with the generator; one clock domain; reset is asynchronous and active-low
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel-rate strobe; inputs sampled only when 1
- h_sync  in  1  horizontal sync
- v_sync  in  1  vertical sync
- Red  in  4  red
- Green  in  4  green
- Blue  in  4  blue
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts write
- wr_addr  out  32  byte address
- wr_data  out  16  {4'h0, R, G, B}
- locked  out  1  timing lock indicator
- frame_done  out  1  one-cycle pulse, last active pixel of frame pushed
- overflow  out  1  sticky, pixel dropped because FIFO full
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, locked=0, frame_done=0, overflow=0; FIFO empty; counters 0; state UNLOCKED.
- Inputs are registered once on pix_ce. Sync edge = transition of the registered sync into the SYNC_POL level.
- h_cnt: cleared to 0 on an hsync edge, otherwise incremented per pix_ce; saturates at 2*H_TOTAL (H_TOTAL = sum of the H parameters).
- v_cnt: cleared on a vsync edge, incremented on each hsync edge.
- States:
  - UNLOCKED: on a vsync edge go to LOCKED; pixel_index=0.
  - LOCKED: locked=1. Capture is active.
  - Lock check: an hsync edge arriving with h_cnt != H_TOTAL-1, or h_cnt reaching 2*H_TOTAL, sends the block to UNLOCKED and drains nothing.
- Capture window: when LOCKED, pix_ce=1, H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE, push {pixel_index<<ADDR_SHIFT, 4'h0,R,G,B} into the FIFO and increment pixel_index.
- Latency: pixel sampled on pix_ce cycle N gives wr_valid high at N+2 at the earliest (input register, then FIFO).
- Write handshake:
  - wr_valid = FIFO not empty; wr_addr and wr_data show the FIFO head.
  - Pop on wr_valid && wr_ready.
  - wr_valid/addr/data stay stable until accepted.
- FIFO full when a push is due: drop the pixel, set overflow, still increment pixel_index so later pixels keep their correct position.
- Simultaneous push and pop on a full FIFO is allowed; the push succeeds.
- pixel_index wraps to 0 after H_ACTIVE*V_ACTIVE-1 (307199) and is also forced to 0 on each vsync edge. frame_done pulses in the cycle the index-307199 pixel is pushed (or dropped).
- clr_ovf=1 clears overflow; if a drop occurs in the same cycle, set wins.
- Loss of lock mid-frame: further pushes stop, and already queued writes still drain.

Optional Feature:
- VGA_CAPTURE_STATS_EN.
- Defined: adds outputs frame_cnt[15:0] (increments on frame_done, wraps) and lock_err_cnt[7:0] (increments on each LOCKED->UNLOCKED transition, saturates at 255). Both reset to 0.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header vga_timing: the H_/V_ timing constants, H_TOTAL, V_TOTAL and the FRAME_PIXELS constant. These are also used by the generator.
- Sub-module vga_capture_fifo: synchronous FIFO, width 48, with push, pop, full, empty and a head output.

Test Plan:
- Generator in loopback with pix_ce every 4 clk and wr_ready=1 -> locked=1 after first vsync edge; 307200 writes per frame, first wr_addr=0, last wr_addr=307199<<4=0x4AFFF0; frame_done once per frame.
- Known pattern R=h%16, G=v%16, B=5 -> wr_data at pixel (x=3,y=2) is 0x0325, with addr (2*640+3)<<4.
- wr_ready held 0 for 10 pixels -> FIFO fills after 4 pixels, overflow=1, the next accepted addresses skip the dropped indices; clr_ovf clears overflow.
- Shorten one line by 8 pixels mid-frame -> locked drops within that hsync edge, no further pushes, relock and index 0 at next vsync.
- Assert rst_n low mid-line with FIFO holding 3 entries -> wr_valid=0 and all outputs 0 immediately; capture resumes only after the next vsync edge.
- Stats build: 3 frames plus 1 forced lock loss -> frame_cnt=3, lock_err_cnt=1.
